// File: rtl/alu_issue_seq.sv
// rtl/alu_issue_seq.sv - command FIFO feeding a multi-cycle ALU, one command in flight.
// Optional res_flags output enabled by defining ALU_SEQ_FLAGS_EN.
module alu_issue_seq #(
   parameter int DEPTH    = 4,
   parameter int WAIT_CYC = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [3:0]  cmd_opcode,
   input  logic [7:0]  cmd_a,
   input  logic [7:0]  cmd_b,
   output logic [3:0]  alu_opcode,
   output logic [7:0]  alu_a,
   output logic [7:0]  alu_b,
   output logic        alu_init,
   output logic        alu_ex_sel,
   input  logic [15:0] alu_result,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [15:0] res_data,
   output logic [3:0]  res_opcode,
   output logic [7:0]  drop_cnt
`ifdef ALU_SEQ_FLAGS_EN
   ,
   output logic [1:0]  res_flags
`endif
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

   state_t      state;
   logic [19:0] mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic [3:0]  wait_cnt;
   logic        full;
   logic        empty;
   logic        push;
   logic        pop;
   logic [19:0] head;
   logic        head_drop;

   // Extra pointer bit separates full (MSBs differ) from empty (pointers equal).
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty     = (wr_ptr == rd_ptr);
   assign cmd_ready = !full;
   assign push      = cmd_valid && cmd_ready;
   assign pop       = (state == IDLE) && !empty;
   assign head      = mem[rd_ptr[AW-1:0]];
   assign head_drop = (head[19:16] == 4'b0000) || (head[19:16] == 4'b1011) ||
                      (head[19:16] == 4'b1111);
   assign alu_ex_sel = 1'b0;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= {cmd_opcode, cmd_a, cmd_b};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
         if (pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         wait_cnt   <= 4'd0;
         alu_opcode <= 4'd0;
         alu_a      <= 8'd0;
         alu_b      <= 8'd0;
         alu_init   <= 1'b0;
         res_valid  <= 1'b0;
         res_data   <= 16'd0;
         res_opcode <= 4'd0;
         drop_cnt   <= 8'd0;
`ifdef ALU_SEQ_FLAGS_EN
         res_flags  <= 2'b00;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (!empty) begin
                  // Dropped opcodes never reach the ALU; the next pop may follow immediately.
                  if (head_drop) begin
                     if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
                  end else begin
                     alu_opcode <= head[19:16];
                     alu_a      <= head[15:8];
                     alu_b      <= head[7:0];
                     alu_init   <= 1'b1;
                     state      <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               wait_cnt <= 4'(WAIT_CYC - 1);
               state    <= WAIT;
            end
            WAIT: begin
               if (wait_cnt == 4'd0) begin
                  res_data   <= alu_result;
                  res_opcode <= alu_opcode;
                  res_valid  <= 1'b1;
                  alu_init   <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
                  res_flags  <= {(alu_result == 16'd0), |alu_result[15:8]};
`endif
                  state      <= HOLD;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            HOLD: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_seq.sv
// tb/tb_alu_issue_seq.sv - randomized self-checking bench for alu_issue_seq with a queue-based model.
module tb_alu_issue_seq;

   localparam int DEPTH    = 4;
   localparam int WAIT_CYC = 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [3:0]  cmd_opcode = 4'd0;
   logic [7:0]  cmd_a = 8'd0;
   logic [7:0]  cmd_b = 8'd0;
   logic [3:0]  alu_opcode;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic        alu_init;
   logic        alu_ex_sel;
   logic [15:0] alu_result;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [15:0] res_data;
   logic [3:0]  res_opcode;
   logic [7:0]  drop_cnt;
`ifdef ALU_SEQ_FLAGS_EN
   logic [1:0]  res_flags;
`endif

   int          n_checks = 0;
   int          n_pass = 0;
   logic [19:0] exp_q[$];
   int          exp_drops = 0;

   always #5 clk = ~clk;

   alu_issue_seq #(.DEPTH(DEPTH), .WAIT_CYC(WAIT_CYC)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b),
      .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
      .alu_init(alu_init), .alu_ex_sel(alu_ex_sel), .alu_result(alu_result),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_opcode(res_opcode), .drop_cnt(drop_cnt)
`ifdef ALU_SEQ_FLAGS_EN
      , .res_flags(res_flags)
`endif
   );

   function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         4'd1:    return 16'(a) + 16'(b);
         4'd2:    return 16'(a) - 16'(b);
         4'd3:    return 16'(a) * 16'(b);
         4'd4:    return {8'h00, a | b};
         4'd5:    return {8'h00, a & b};
         4'd6:    return {8'h00, a ^ b};
         4'd7:    return 16'(a) << b[3:0];
         default: return {a, b};
      endcase
   endfunction

   assign alu_result = alu_fn(alu_opcode, alu_a, alu_b);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic void model_push(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      if (op == 4'd0 || op == 4'd11 || op == 4'd15) begin
         if (exp_drops < 255) exp_drops++;
      end else begin
         exp_q.push_back({op, alu_fn(op, a, b)});
      end
   endfunction

   task automatic push(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      int n = 0;
      while (!cmd_ready && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      if (!cmd_ready) check("push_ready_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1; cmd_opcode = op; cmd_a = a; cmd_b = b;
      if (cmd_ready) model_push(op, a, b);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      res_ready = 1'b1;
      while (exp_q.size() != 0 && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain_empty", 32'(exp_q.size()), 32'd0);
      repeat (2 * DEPTH + 4) @(posedge clk);
      #1;
      check("drain_idle_valid", 32'(res_valid), 32'd0);
      check("drop_cnt", 32'(drop_cnt), 32'(exp_drops));
   endtask

   always @(negedge clk) begin
      if (!rst && res_valid && res_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", 32'(res_data), 32'hFFFF_FFFF);
         end else begin
            logic [19:0] e;
            e = exp_q.pop_front();
            check("res_opcode", 32'(res_opcode), 32'(e[19:16]));
            check("res_data", 32'(res_data), 32'(e[15:0]));
`ifdef ALU_SEQ_FLAGS_EN
            check("res_flags", 32'(res_flags), {30'd0, (e[15:0] == 16'd0), |e[15:8]});
`endif
         end
      end
   end

   initial begin
      int n;
      logic seen;
      logic [3:0] drop_ops [3];
      drop_ops[0] = 4'd0; drop_ops[1] = 4'd11; drop_ops[2] = 4'd15;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_res_data", 32'(res_data), 32'd0);
      check("rst_res_opcode", 32'(res_opcode), 32'd0);
      check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
      check("rst_alu_init", 32'(alu_init), 32'd0);
      check("rst_alu_regs", {12'd0, alu_opcode, alu_a, alu_b}, 32'd0);
      check("alu_ex_sel", 32'(alu_ex_sel), 32'd0);

      // Single add: ISSUE, WAIT, then res_valid.
      res_ready = 1'b1;
      push(4'd1, 8'd10, 8'd20);
      n = 0;
      @(negedge clk);
      while (!alu_init && n < 50) begin @(negedge clk); n++; end
      check("add_issue", {alu_init, alu_opcode, alu_a, alu_b}, {1'b1, 4'd1, 8'd10, 8'd20});
      check("add_issue_valid", 32'(res_valid), 32'd0);
      @(negedge clk);
      check("add_wait", {alu_init, res_valid}, 2'b10);
      @(negedge clk);
      check("add_hold", {alu_init, res_valid}, 2'b01);
      check("add_data", {res_opcode, res_data}, {4'd1, 16'd30});
      drain();

      // Back-pressure: one command held in HOLD plus DEPTH queued fills the FIFO.
      res_ready = 1'b0;
      for (int i = 0; i < DEPTH + 1; i++) push(4'(i + 1), 8'($urandom), 8'($urandom));
      check("bp_full", 32'(cmd_ready), 32'd0);
      repeat (20) @(posedge clk);
      #1;
      check("bp_hold_valid", 32'(res_valid), 32'd1);
      check("bp_hold_init", 32'(alu_init), 32'd0);
      check("bp_still_full", 32'(cmd_ready), 32'd0);
      drain();

      push(4'd0, 8'd1, 8'd2);
      push(4'd11, 8'd3, 8'd4);
      push(4'd15, 8'd5, 8'd6);
      push(4'd5, 8'hF0, 8'h3C);
      drain();
      check("three_drops", 32'(drop_cnt), 32'd3);

      push(4'd2, 8'd5, 8'd5);
      push(4'd3, 8'd16, 8'd16);
      drain();

      for (int i = 0; i < 500; i++) begin
         res_ready  = ($urandom % 4) != 0;
         cmd_valid  = ($urandom % 2) != 0;
         cmd_opcode = 4'($urandom);
         cmd_a      = 8'($urandom);
         cmd_b      = 8'($urandom);
         if (cmd_valid && cmd_ready) model_push(cmd_opcode, cmd_a, cmd_b);
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      drain();

      // Reset during WAIT discards the in-flight mul and the queued command.
      res_ready = 1'b1;
      push(4'd3, 8'd255, 8'd255);
      push(4'd1, 8'd1, 8'd1);
      n = 0;
      @(negedge clk);
      while (!(alu_init && alu_opcode == 4'd3) && n < 50) begin @(negedge clk); n++; end
      check("mul_issue", {alu_init, alu_opcode}, {1'b1, 4'd3});
      @(negedge clk);
      check("mul_wait", {alu_init, res_valid}, 2'b10);
      rst = 1'b1;
      exp_q.delete();
      exp_drops = 0;
      #1;
      check("midrst_outputs", {res_valid, alu_init, drop_cnt, alu_opcode, alu_a, alu_b}, 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (res_valid || alu_init || !cmd_ready) seen = 1'b1;
      end
      check("midrst_quiet", 32'(seen), 32'd0);

      for (int i = 0; i < 260; i++) push(drop_ops[i % 3], 8'($urandom), 8'($urandom));
      drain();
      check("drop_sat", 32'(drop_cnt), 32'd255);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
